// File: rtl/axi_lite_arb_pkg.sv
// Shared types and constants for the two-master AXI-lite arbiter.
package axi_lite_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_RESP
    } arb_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: on a tie the master that did not win last time gets the grant.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_grant ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/axi_lite_arbiter.sv
// Two upstream AXI-lite masters share one downstream AXI-lite port; one transaction
// in flight at a time, round-robin between masters, write before read within a master.
module axi_lite_arbiter
    import axi_lite_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    // upstream AW
    input  logic [1:0][ADDR_W-1:0]       s_awaddr,
    input  logic [1:0]                   s_awvalid,
    output logic [1:0]                   s_awready,
    // upstream W
    input  logic [1:0][DATA_W-1:0]       s_wdata,
    input  logic [1:0][DATA_W/8-1:0]     s_wstrb,
    input  logic [1:0]                   s_wvalid,
    output logic [1:0]                   s_wready,
    // upstream B
    output logic [1:0][1:0]              s_bresp,
    output logic [1:0]                   s_bvalid,
    input  logic [1:0]                   s_bready,
    // upstream AR
    input  logic [1:0][ADDR_W-1:0]       s_araddr,
    input  logic [1:0]                   s_arvalid,
    output logic [1:0]                   s_arready,
    // upstream R
    output logic [1:0][DATA_W-1:0]       s_rdata,
    output logic [1:0][1:0]              s_rresp,
    output logic [1:0]                   s_rvalid,
    input  logic [1:0]                   s_rready,
    // downstream
    output logic [ADDR_W-1:0]            m_awaddr,
    output logic                         m_awvalid,
    input  logic                         m_awready,
    output logic [DATA_W-1:0]            m_wdata,
    output logic [DATA_W/8-1:0]          m_wstrb,
    output logic                         m_wvalid,
    input  logic                         m_wready,
    input  logic [1:0]                   m_bresp,
    input  logic                         m_bvalid,
    output logic                         m_bready,
    output logic [ADDR_W-1:0]            m_araddr,
    output logic                         m_arvalid,
    input  logic                         m_arready,
    input  logic [DATA_W-1:0]            m_rdata,
    input  logic [1:0]                   m_rresp,
    input  logic                         m_rvalid,
    output logic                         m_rready,
    // status
    output logic [1:0]                   gnt,
    output logic                         busy
);

    arb_state_e state_q, state_d;
    logic [1:0] gnt_q, gnt_d;
    logic       last_grant_q, last_grant_d;
    logic       aw_done_q, aw_done_d;
    logic       w_done_q, w_done_d;

    logic [1:0] wr_req, rd_req, req, pick;
    logic       idx;

    assign wr_req = s_awvalid & s_wvalid;
    assign rd_req = s_arvalid;
    assign req    = wr_req | rd_req;
    assign idx    = gnt_q[1];

    rr_arb2 u_rr_arb2 (
        .req        (req),
        .last_grant (last_grant_q),
        .gnt        (pick)
    );

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_grant_d = last_grant_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;

        // Payloads follow the owner unconditionally; only valid/ready are state-gated.
        m_awaddr  = s_awaddr[idx];
        m_wdata   = s_wdata[idx];
        m_wstrb   = s_wstrb[idx];
        m_araddr  = s_araddr[idx];
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        m_bready  = 1'b0;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;

        s_awready = '0;
        s_wready  = '0;
        s_bvalid  = '0;
        s_bresp   = '0;
        s_arready = '0;
        s_rvalid  = '0;
        s_rresp   = '0;
        s_rdata   = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    gnt_d   = pick;
                    state_d = (|(wr_req & pick)) ? ST_WR_REQ : ST_RD_REQ;
                end
            end
            ST_WR_REQ: begin
                m_awvalid      = s_awvalid[idx] & ~aw_done_q;
                m_wvalid       = s_wvalid[idx] & ~w_done_q;
                s_awready[idx] = m_awready & ~aw_done_q;
                s_wready[idx]  = m_wready & ~w_done_q;
                aw_done_d      = aw_done_q | (m_awvalid & m_awready);
                w_done_d       = w_done_q | (m_wvalid & m_wready);
                if (aw_done_d && w_done_d) begin
                    state_d   = ST_WR_RESP;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            ST_WR_RESP: begin
                m_bready      = s_bready[idx];
                s_bvalid[idx] = m_bvalid;
                s_bresp[idx]  = m_bresp;
                if (m_bvalid && m_bready) begin
                    state_d      = ST_IDLE;
                    gnt_d        = '0;
                    last_grant_d = idx;
                end
            end
            ST_RD_REQ: begin
                m_arvalid      = s_arvalid[idx];
                s_arready[idx] = m_arready;
                if (m_arvalid && m_arready) begin
                    state_d = ST_RD_RESP;
                end
            end
            ST_RD_RESP: begin
                m_rready      = s_rready[idx];
                s_rvalid[idx] = m_rvalid;
                s_rresp[idx]  = m_rresp;
                s_rdata[idx]  = m_rdata;
                if (m_rvalid && m_rready) begin
                    state_d      = ST_IDLE;
                    gnt_d        = '0;
                    last_grant_d = idx;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // last_grant resets to 1 so master 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            gnt_q        <= '0;
            last_grant_q <= 1'b1;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            last_grant_q <= last_grant_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
        end
    end

    assign gnt  = gnt_q;
    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed bench: two scripted masters, a 4-register AXI-lite slave model downstream.
module tb_axi_lite_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0][31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
    logic [1:0][3:0]  s_wstrb;
    logic [1:0][1:0]  s_bresp, s_rresp;
    logic [1:0]       s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [1:0]       s_arvalid, s_arready, s_rvalid, s_rready;
    logic [31:0]      m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [3:0]       m_wstrb;
    logic [1:0]       m_bresp, m_rresp;
    logic             m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic             m_arvalid, m_arready, m_rvalid, m_rready;
    logic [1:0]       gnt;
    logic             busy;

    axi_lite_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .gnt(gnt), .busy(busy)
    );

    // Slave model: registers at 0x0/0x4/0x8/0xC, anything else is SLVERR / 0xDEADBEEF.
    logic [31:0] regs [4];
    logic        have_aw, have_w, slave_w_en;
    logic [31:0] aw_a, w_d;
    logic [3:0]  w_s;

    assign m_awready = !have_aw && !m_bvalid;
    assign m_wready  = !have_w && !m_bvalid && slave_w_en;
    assign m_arready = !m_rvalid;

    always_ff @(posedge clk) begin
        if (rst) begin
            have_aw <= 1'b0; have_w <= 1'b0;
            m_bvalid <= 1'b0; m_bresp <= 2'b00;
            m_rvalid <= 1'b0; m_rresp <= 2'b00; m_rdata <= '0;
            aw_a <= '0; w_d <= '0; w_s <= '0;
            for (int r = 0; r < 4; r++) regs[r] <= '0;
        end else begin
            if (m_awvalid && m_awready) begin have_aw <= 1'b1; aw_a <= m_awaddr; end
            if (m_wvalid && m_wready) begin have_w <= 1'b1; w_d <= m_wdata; w_s <= m_wstrb; end
            if (have_aw && have_w) begin
                have_aw  <= 1'b0;
                have_w   <= 1'b0;
                m_bvalid <= 1'b1;
                if (aw_a < 32'h10) begin
                    m_bresp <= 2'b00;
                    for (int b = 0; b < 4; b++)
                        if (w_s[b]) regs[aw_a[3:2]][b*8 +: 8] <= w_d[b*8 +: 8];
                end else begin
                    m_bresp <= 2'b10;
                end
            end
            if (m_bvalid && m_bready) m_bvalid <= 1'b0;
            if (m_arvalid && m_arready) begin
                m_rvalid <= 1'b1;
                if (m_araddr < 32'h10) begin
                    m_rdata <= regs[m_araddr[3:2]]; m_rresp <= 2'b00;
                end else begin
                    m_rdata <= 32'hDEAD_BEEF; m_rresp <= 2'b10;
                end
            end
            if (m_rvalid && m_rready) m_rvalid <= 1'b0;
        end
    end

    int n_cmp = 0;
    int n_err = 0;
    int b_cnt [2];
    int r_cnt [2];
    logic [1:0]  b_last [2];
    logic [1:0]  r_last_resp [2];
    logic [31:0] r_last_data [2];
    logic        rv0_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: log handshakes seen before the edge, advance, drop accepted valids.
    task automatic tick();
        logic [1:0] aw_hs, w_hs, ar_hs, b_hs, r_hs;
        aw_hs = s_awvalid & s_awready;
        w_hs  = s_wvalid & s_wready;
        ar_hs = s_arvalid & s_arready;
        b_hs  = s_bvalid & s_bready;
        r_hs  = s_rvalid & s_rready;
        if (s_rvalid[0]) rv0_seen = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (b_hs[i]) begin b_cnt[i]++; b_last[i] = s_bresp[i]; end
            if (r_hs[i]) begin r_cnt[i]++; r_last_resp[i] = s_rresp[i]; r_last_data[i] = s_rdata[i]; end
        end
        @(posedge clk);
        @(negedge clk);
        s_awvalid = s_awvalid & ~aw_hs;
        s_wvalid  = s_wvalid & ~w_hs;
        s_arvalid = s_arvalid & ~ar_hs;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_awvalid = '0; s_wvalid = '0; s_arvalid = '0;
        s_bready = 2'b11; s_rready = 2'b11;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic wr(input int m, input logic [31:0] a, input logic [31:0] d);
        s_awaddr[m] = a; s_wdata[m] = d; s_wstrb[m] = 4'hF;
        s_awvalid[m] = 1'b1; s_wvalid[m] = 1'b1;
    endtask

    task automatic rd(input int m, input logic [31:0] a);
        s_araddr[m] = a; s_arvalid[m] = 1'b1;
    endtask

    task automatic wait_b(input int m, input int target, input string tag);
        int n = 0;
        while (b_cnt[m] < target && n < 60) begin tick(); n++; end
        chk(tag, 32'(b_cnt[m] >= target), 32'd1);
    endtask

    task automatic wait_r(input int m, input int target, input string tag);
        int n = 0;
        while (r_cnt[m] < target && n < 60) begin tick(); n++; end
        chk(tag, 32'(r_cnt[m] >= target), 32'd1);
    endtask

    initial begin
        int n;
        b_cnt = '{0, 0}; r_cnt = '{0, 0};
        b_last = '{2'b11, 2'b11}; r_last_resp = '{2'b11, 2'b11}; r_last_data = '{0, 0};
        rv0_seen = 1'b0; slave_w_en = 1'b1;
        s_awaddr = '0; s_wdata = '0; s_wstrb = '0; s_araddr = '0;
        s_awvalid = '0; s_wvalid = '0; s_arvalid = '0; s_bready = 2'b11; s_rready = 2'b11;
        @(negedge clk);
        do_reset();

        chk("rst_busy", 32'(busy), 0);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_mvalid", 32'({m_awvalid, m_wvalid, m_arvalid}), 0);
        chk("rst_sready", 32'({s_awready, s_wready, s_arready}), 0);

        // single write by M0, read back through M1
        wr(0, 32'h4, 32'h1234_5678);
        chk("idle_awvalid", 32'(m_awvalid), 0);
        tick();
        chk("w1_gnt", 32'(gnt), 32'h1);
        chk("w1_busy", 32'(busy), 1);
        chk("w1_awvalid", 32'(m_awvalid), 1);
        chk("w1_awaddr", m_awaddr, 32'h4);
        chk("w1_awready_m1", 32'(s_awready[1]), 0);
        wait_b(0, 1, "w1_b_timeout");
        chk("w1_bresp", 32'(b_last[0]), 32'h0);
        rd(1, 32'h4);
        wait_r(1, 1, "r1_timeout");
        chk("r1_data", r_last_data[1], 32'h1234_5678);
        chk("r1_resp", 32'(r_last_resp[1]), 32'h0);

        // simultaneous writes after reset: M0 then M1
        do_reset();
        wr(0, 32'h8, 32'hAAAA_AAAA);
        wr(1, 32'h8, 32'h5555_5555);
        tick();
        chk("tie_first_gnt", 32'(gnt), 32'h1);
        wait_b(0, 2, "tie_b0_timeout");
        chk("tie_idle_gnt", 32'(gnt), 0);
        tick();
        chk("tie_second_gnt", 32'(gnt), 32'h2);
        wait_b(1, 1, "tie_b1_timeout");
        rd(0, 32'h8);
        wait_r(0, 1, "tie_r_timeout");
        chk("tie_final", r_last_data[0], 32'h5555_5555);

        // out-of-range read by M1
        rv0_seen = 1'b0;
        rd(1, 32'h10);
        wait_r(1, 2, "oor_timeout");
        chk("oor_resp", 32'(r_last_resp[1]), 32'h2);
        chk("oor_data", r_last_data[1], 32'hDEAD_BEEF);
        chk("oor_no_rvalid_m0", 32'(rv0_seen), 0);

        // M0 stalls B for 5 cycles while M1 waits with a read
        s_bready[0] = 1'b0;
        wr(0, 32'hC, 32'hCAFE_F00D);
        n = 0;
        while (!s_bvalid[0] && n < 20) begin tick(); n++; end
        chk("stall_bvalid", 32'(s_bvalid[0]), 1);
        rd(1, 32'hC);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("stall_gnt", 32'(gnt), 32'h1);
            chk("stall_arready_m1", 32'(s_arready[1]), 0);
        end
        s_bready[0] = 1'b1;
        tick();
        chk("stall_idle_busy", 32'(busy), 0);
        chk("stall_idle_arvalid", 32'(m_arvalid), 0);
        tick();
        chk("stall_ar_gnt", 32'(gnt), 32'h2);
        chk("stall_ar_valid", 32'(m_arvalid), 1);
        chk("stall_ar_addr", m_araddr, 32'hC);
        wait_r(1, 3, "stall_r_timeout");
        chk("stall_r_data", r_last_data[1], 32'hCAFE_F00D);

        // M0 write and read pending together: write first
        n = b_cnt[0];
        wr(0, 32'h0, 32'h0BAD_C0DE);
        rd(0, 32'h0);
        tick();
        chk("wfirst_awvalid", 32'(m_awvalid), 1);
        chk("wfirst_arvalid", 32'(m_arvalid), 0);
        wait_r(0, 2, "wfirst_r_timeout");
        chk("wfirst_b_done", 32'(b_cnt[0]), 32'(n + 1));
        chk("wfirst_r_data", r_last_data[0], 32'h0BAD_C0DE);

        // reset between AW and W handshakes
        slave_w_en = 1'b0;
        wr(1, 32'h4, 32'h1111_2222);
        tick();
        tick();
        chk("mid_awvalid_gated", 32'(m_awvalid), 0);
        chk("mid_wvalid", 32'(m_wvalid), 1);
        chk("mid_busy", 32'(busy), 1);
        rst = 1'b1;
        tick();
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_gnt", 32'(gnt), 0);
        chk("mid_rst_mvalid", 32'({m_awvalid, m_wvalid, m_arvalid}), 0);
        rst = 1'b0;
        s_wvalid = '0;
        slave_w_en = 1'b1;
        n = b_cnt[1];
        wr(1, 32'h4, 32'h3333_4444);
        wait_b(1, n + 1, "post_rst_b_timeout");
        chk("post_rst_bresp", 32'(b_last[1]), 32'h0);
        rd(0, 32'h4);
        wait_r(0, 3, "post_rst_r_timeout");
        chk("post_rst_data", r_last_data[0], 32'h3333_4444);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axi_lite_arbiter.md
AXI_LITE_ARBITER -- requirements
Module: axi_lite_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width of all AW/AR channels.
REQ-002 SHALL have parameter DATA_W, default 32, data width; strobe width is DATA_W/8.
REQ-003 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have AW ports s_awaddr in 2xADDR_W, s_awvalid in 2, s_awready out 2; upstream write-address channels, index 0/1 = master 0/1.
REQ-006 SHALL have W ports s_wdata in 2xDATA_W, s_wstrb in 2xDATA_W/8, s_wvalid in 2, s_wready out 2; upstream write-data channels.
REQ-007 SHALL have B ports s_bresp out 2x2, s_bvalid out 2, s_bready in 2; upstream write-response channels.
REQ-008 SHALL have AR ports s_araddr in 2xADDR_W, s_arvalid in 2, s_arready out 2; upstream read-address channels.
REQ-009 SHALL have R ports s_rdata out 2xDATA_W, s_rresp out 2x2, s_rvalid out 2, s_rready in 2; upstream read-data channels.
REQ-010 SHALL have downstream ports m_awaddr/m_awvalid/m_awready, m_wdata/m_wstrb/m_wvalid/m_wready, m_bresp/m_bvalid/m_bready, m_araddr/m_arvalid/m_arready, m_rdata/m_rresp/m_rvalid/m_rready; one AXI-lite master port to the register slave, directions mirrored from upstream.
REQ-011 SHALL have port gnt  out  2  one-hot owner of the current transaction, 0 in IDLE.
REQ-012 SHALL have port busy  out  1  high in every state other than IDLE.

Function
REQ-013 SHALL allow exactly one transaction (read or write) outstanding on the m_ port at any time.
REQ-014 SHALL treat master i as requesting a write when s_awvalid[i] and s_wvalid[i] are both high, and a read when s_arvalid[i] is high.
REQ-015 SHALL implement FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP.
REQ-016 SHALL, in IDLE, with one master requesting, grant it; with both requesting, grant the master other than last_grant (round-robin).
REQ-017 SHALL, within the granted master, select write over read when both are pending.
REQ-018 SHALL register the grant and leave IDLE on the edge after the request is seen; m_*valid SHALL be 0 throughout IDLE, so latency from request to m_awvalid/m_arvalid is 1 cycle.
REQ-019 SHALL, in WR_REQ, drive m_aw* and m_w* combinationally from the granted master, and return m_awready/m_wready only to that master.
REQ-020 SHALL track aw_done and w_done flags; m_awvalid SHALL be gated low once aw_done is set, and m_wvalid once w_done is set; AW and W handshakes may occur in the same or in different cycles.
REQ-021 SHALL move WR_REQ->WR_RESP on the edge where both handshakes are complete, then clear both flags.
REQ-022 SHALL, in WR_RESP, pass m_bvalid/m_bresp to the granted master and s_bready of that master to m_bready; on m_bvalid&&m_bready it SHALL go to IDLE and set last_grant to the granted index.
REQ-023 SHALL, in RD_REQ, pass AR of the granted master; on m_arvalid&&m_arready it SHALL go to RD_RESP.
REQ-024 SHALL, in RD_RESP, pass m_rdata/m_rresp/m_rvalid to the granted master and its s_rready to m_rready; on handshake it SHALL go to IDLE and update last_grant.
REQ-025 SHALL hold every ready, valid, resp and rdata output toward a non-granted master at 0.
REQ-026 SHALL pass bresp/rresp values (OKAY 2'b00, SLVERR 2'b10) and rdata unmodified.
REQ-027 SHALL not re-arbitrate while busy; requests arriving mid-transaction wait and are arbitrated in IDLE.

Reset
REQ-028 SHALL, when rst is high at a clock edge, force state=IDLE, aw_done=w_done=0, last_grant=1 (master 0 wins the first tie), gnt=0, busy=0 and all valid/ready outputs to 0, including mid-transaction; the downstream slave is reset in the same cycle.

Structure
REQ-029 SHALL take the state enum and the OKAY/SLVERR response constants from shared package axi_lite_arb_pkg.
REQ-030 SHALL place the two-way round-robin pick (requests, last_grant -> one-hot grant) in sub-module rr_arb2.

Verification
REQ-031 Master 0 writes 0x1234_5678, strobe 0xF, to address 0x4 -> register 1 reads back 0x1234_5678 through master 1, OKAY on both.
REQ-032 Both masters issue writes to 0x8 in the same cycle after reset (M0 0xAAAA_AAAA, M1 0x5555_5555) -> M0 granted first, M1 second; final read gives 0x5555_5555.
REQ-033 Master 1 reads 0x10 (out of range) -> s_rresp[1]=2'b10, s_rdata[1]=0xDEAD_BEEF, and master 0 sees no rvalid.
REQ-034 Master 0 holds s_bready low for 5 cycles while master 1 asserts arvalid -> master 1 is not granted until the B handshake completes, and the AR then follows 1 cycle after IDLE.
REQ-035 Master 0 has both a write and a read pending -> write is performed first, then the read returns the newly written value.
REQ-036 rst asserted in WR_REQ after the AW handshake but before the W handshake -> next cycle busy=0, gnt=0, all m_*valid=0, and a new write then completes normally.
